// File: rtl/cim_pkg.sv
// Shared defaults and the queue-entry layout for the CIM tile accumulator.
// The FIFO stores entries packed as {tile, addr, first}, matching entry_t.
package cim_pkg;

  localparam int unsigned TILE_DEF   = 6;
  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned LINE_W_DEF = 512;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 4;

  localparam int unsigned TILE_BITS_DEF = TILE_DEF * TILE_DEF * DATA_W_DEF;

  typedef struct packed {
    logic [TILE_BITS_DEF-1:0] tile;
    logic [ADDR_W_DEF-1:0]    addr;
    logic                     first;
  } entry_t;

endpackage

// File: rtl/cim_fifo.sv
// Synchronous FIFO with occupancy count; pushes are refused when full even if a
// pop happens in the same cycle, and the head is only visible after the push edge.
module cim_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cim_accum.sv
// Compute-in-memory tile accumulator: queues PE tiles, pairs each with a matching
// partial-sum line (unless first pass) and adds element-wise with optional saturation.
module cim_accum
  import cim_pkg::*;
#(
  parameter int unsigned TILE   = TILE_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [TILE*TILE*DATA_W-1:0] pe_tile_i,
  input  logic [ADDR_W-1:0]          pe_addr_i,
  input  logic                       pe_first_i,
  input  logic                       pe_valid_i,
  output logic                       pe_ready_o,
  input  logic [LINE_W-1:0]          mem_data_i,
  input  logic [ADDR_W-1:0]          mem_addr_i,
  input  logic                       mem_valid_i,
  output logic                       mem_ready_o,
  input  logic                       sat_en_i,
  output logic [LINE_W-1:0]          result_o,
  output logic [ADDR_W-1:0]          result_addr_o,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic                       mismatch_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned TILE_BITS = TILE * TILE * DATA_W;
  localparam int unsigned ENTRY_W   = TILE_BITS + ADDR_W + 1;
  localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;

  logic [ENTRY_W-1:0]   head;
  logic [TILE_BITS-1:0] head_tile;
  logic [ADDR_W-1:0]    head_addr;
  logic                 head_first;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  logic                 free;
  logic                 mem_fire;
  logic                 addr_match;
  logic                 pop;

  logic [TILE_BITS-1:0] sum_tile;
  logic [DATA_W-1:0]    elem_a;
  logic [DATA_W-1:0]    elem_b;
  logic [DATA_W:0]      elem_sum;
  logic [DATA_W-1:0]    elem_res;
  logic [LINE_W-1:0]    result_d;

  logic [LINE_W-1:0]    result_q;
  logic [ADDR_W-1:0]    result_addr_q;
  logic                 result_valid_q;
  logic                 mismatch_q;

  assign {head_tile, head_addr, head_first} = head;

  cim_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (pe_valid_i && pe_ready_o),
    .push_data_i ({pe_tile_i, pe_addr_i, pe_first_i}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign free        = !result_valid_q || result_ready_i;
  assign pe_ready_o  = !reset && !fifo_full;
  assign mem_ready_o = !reset && !fifo_empty && !head_first && free;
  assign mem_fire    = mem_valid_i && mem_ready_o;
  assign addr_match  = (mem_addr_i == head_addr);
  assign pop         = !reset && !fifo_empty && free && (head_first || (mem_fire && addr_match));

  // Sign-extend by one bit; overflow shows as disagreement of the top two sum bits.
  always_comb begin
    sum_tile = '0;
    elem_a   = '0;
    elem_b   = '0;
    elem_sum = '0;
    elem_res = '0;
    for (int e = 0; e < TILE * TILE; e++) begin
      elem_a   = head_tile[e*DATA_W +: DATA_W];
      elem_b   = mem_data_i[e*DATA_W +: DATA_W];
      elem_sum = {elem_a[DATA_W-1], elem_a} + {elem_b[DATA_W-1], elem_b};
      if (sat_en_i && (elem_sum[DATA_W] ^ elem_sum[DATA_W-1])) begin
        elem_res = elem_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        elem_res = elem_sum[DATA_W-1:0];
      end
      sum_tile[e*DATA_W +: DATA_W] = elem_res;
    end
  end

  always_comb begin
    result_d = '0;
    result_d[TILE_BITS-1:0] = head_first ? head_tile : sum_tile;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q       <= '0;
      result_addr_q  <= '0;
      result_valid_q <= 1'b0;
      mismatch_q     <= 1'b0;
    end else begin
      mismatch_q <= mem_fire && !addr_match;
      if (pop) begin
        result_q       <= result_d;
        result_addr_q  <= head_addr;
        result_valid_q <= 1'b1;
      end else if (result_ready_i) begin
        result_valid_q <= 1'b0;
      end
    end
  end

  if (LINE_W > TILE_BITS) begin : g_pad
    logic unused_mem_bits;
    assign unused_mem_bits = ^mem_data_i[LINE_W-1:TILE_BITS];
  end

  assign result_o       = result_q;
  assign result_addr_o  = result_addr_q;
  assign result_valid_o = result_valid_q;
  assign mismatch_o     = mismatch_q;
  assign count_o        = fifo_count;

endmodule
